// File: rtl/instr_fetch.sv
// instr_fetch: owns the program counter, addresses the combinational instruction ROM and
// registers the returned word for the decoder. Optional macro FETCH_CYCLE_COUNT_EN enables o_cycle_count.
module instr_fetch #(
    parameter int unsigned PC_W       = 10,
    parameter logic [8:0]  NOP_INSTR  = 9'h100,
    parameter logic [8:0]  HALT_INSTR = 9'h1FF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [PC_W-1:0] i_start_addr,
    input  logic            i_stall,
    input  logic            i_branch_req,
    input  logic [PC_W-1:0] i_branch_target,
    output logic [PC_W-1:0] o_rom_addr,
    input  logic [8:0]      i_rom_data,
    output logic [8:0]      o_instruction,
    output logic            o_instr_valid,
    output logic [PC_W-1:0] o_prog_counter,
    output logic            o_done,
    output logic [15:0]     o_cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] r_prog_counter;
    logic [PC_W-1:0] w_prog_counter_nxt;
    logic [8:0]      r_instr;
    logic [8:0]      w_instr_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_is_halt;
    logic [PC_W-1:0] w_pc_inc;

    assign w_is_halt = r_valid && (r_instr == HALT_INSTR);
    assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // Next-state and next-register values; halt outranks branch, branch outranks sequential fetch.
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_prog_counter_nxt = r_prog_counter;
        w_instr_nxt        = r_instr;
        w_valid_nxt        = r_valid;
        w_done_nxt         = r_done;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_pc_nxt    = i_start_addr;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_stall) begin
                    w_state_nxt = S_RUN;
                end else if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                    w_done_nxt  = 1'b1;
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end else if (i_branch_req && r_valid) begin
                    // The word on i_rom_data is the wrong path; replace it with a bubble.
                    w_pc_nxt    = i_branch_target;
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_instr_nxt        = i_rom_data;
                    w_prog_counter_nxt = r_pc;
                    w_valid_nxt        = 1'b1;
                    w_pc_nxt           = w_pc_inc;
                end
            end
            S_HALT: begin
                if (i_start) begin
                    w_pc_nxt    = i_start_addr;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_instr_nxt = NOP_INSTR;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_pc           <= {PC_W{1'b0}};
            r_prog_counter <= {PC_W{1'b0}};
            r_instr        <= NOP_INSTR;
            r_valid        <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_prog_counter <= w_prog_counter_nxt;
            r_instr        <= w_instr_nxt;
            r_valid        <= w_valid_nxt;
            r_done         <= w_done_nxt;
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;
    logic        w_cnt_clr;
    logic        w_cnt_inc;

    assign w_cnt_clr = ((r_state == S_IDLE) || (r_state == S_HALT)) && i_start;
    assign w_cnt_inc = (r_state == S_RUN) && !i_stall && (r_cycle_count != 16'hFFFF);

    // Saturating count of non-stalled RUN cycles, cleared by every accepted start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_count <= 16'h0000;
        end else if (w_cnt_clr) begin
            r_cycle_count <= 16'h0000;
        end else if (w_cnt_inc) begin
            r_cycle_count <= r_cycle_count + 16'h0001;
        end else begin
            r_cycle_count <= r_cycle_count;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = 16'h0000;
`endif

    assign o_rom_addr     = r_pc;
    assign o_instruction  = r_instr;
    assign o_instr_valid  = r_valid;
    assign o_prog_counter = r_prog_counter;
    assign o_done         = r_done;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected (instruction, address) pairs,
// a negedge monitor pops one per freshly presented valid instruction.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic [9:0]  start_addr;
    logic        stall;
    logic        branch_req;
    logic [9:0]  branch_target;
    logic [9:0]  rom_addr;
    logic [8:0]  rom_data;
    logic [8:0]  instruction;
    logic        instr_valid;
    logic [9:0]  prog_counter;
    logic        done;
    logic [15:0] cycle_count;

    logic [8:0]  rom [0:1023];
    logic        last_stall;

    typedef struct packed {
        logic [8:0] instr;
        logic [9:0] pc;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch #(.PC_W(10), .NOP_INSTR(9'h100), .HALT_INSTR(9'h1FF)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_start_addr    (start_addr),
        .i_stall         (stall),
        .i_branch_req    (branch_req),
        .i_branch_target (branch_target),
        .o_rom_addr      (rom_addr),
        .i_rom_data      (rom_data),
        .o_instruction   (instruction),
        .o_instr_valid   (instr_valid),
        .o_prog_counter  (prog_counter),
        .o_done          (done),
        .o_cycle_count   (cycle_count)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef FETCH_CYCLE_COUNT_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic push(input logic [8:0] ins, input logic [9:0] pc);
        exp_t e;
        e.instr = ins;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) last_stall <= stall;

    // Monitor: a valid instruction after a non-stalled edge is a new one and must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid === 1'b1 && last_stall === 1'b0) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_instr: got %0h at pc %0h expected none", instruction, prog_counter);
            end else begin
                e = sb_q.pop_front();
                check("sb_instruction", 32'(instruction), 32'(e.instr));
                check("sb_prog_counter", 32'(prog_counter), 32'(e.pc));
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 255);
        rom[3] = 9'h1FF;
        rom[5] = 9'h041;
        rom[6] = 9'h042;
        rom[7] = 9'h043;
        reset = 1'b1; start = 1'b0; start_addr = 10'd0; stall = 1'b0;
        branch_req = 1'b0; branch_target = 10'd0;

        step(); step();
        reset = 1'b0;
        check("rst_instruction", 32'(instruction), 32'h100);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_prog_counter", 32'(prog_counter), 32'h0);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cycle_count", 32'(cycle_count), 32'h0);

        // Start at 5, sequential fetch
        start = 1'b1; start_addr = 10'd5; step(); start = 1'b0;
        check("start_rom_addr", 32'(rom_addr), 32'd5);
        check("start_valid", 32'(instr_valid), 32'h0);
        push(9'h041, 10'd5); step();
        push(9'h042, 10'd6); step();
        push(9'h043, 10'd7); step();
        push(9'h008, 10'd8); step();

        // Branch to 20 while addr 8 is in the instruction register
        branch_req = 1'b1; branch_target = 10'd20; step(); branch_req = 1'b0;
        check("bubble_valid", 32'(instr_valid), 32'h0);
        check("bubble_instruction", 32'(instruction), 32'h100);
        check("bubble_rom_addr", 32'(rom_addr), 32'd20);
        push(9'h014, 10'd20); step();
        push(9'h015, 10'd21); step();

        // Three stalled cycles, with a branch request that must be ignored
        stall = 1'b1; branch_req = 1'b1; branch_target = 10'd100;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_instruction", 32'(instruction), 32'h015);
            check("stall_prog_counter", 32'(prog_counter), 32'd21);
            check("stall_rom_addr", 32'(rom_addr), 32'd22);
            check("stall_cycle_count", 32'(cycle_count), exp_cnt(7));
        end
        stall = 1'b0; branch_req = 1'b0;
        push(9'h016, 10'd22); step();
        push(9'h017, 10'd23); step();
        check("post_stall_count", 32'(cycle_count), exp_cnt(9));

        // Start while running is ignored
        start = 1'b1; start_addr = 10'd1022;
        push(9'h018, 10'd24); step(); start = 1'b0;
        check("run_start_ignored", 32'(rom_addr), 32'd25);

        // PC wrap from the top of the address space
        reset = 1'b1; step(); reset = 1'b0;
        check("rst2_count", 32'(cycle_count), 32'h0);
        start = 1'b1; start_addr = 10'd1022; step(); start = 1'b0;
        push(9'h0FE, 10'd1022); step();
        push(9'h0FF, 10'd1023); step();
        check("wrap_rom_addr", 32'(rom_addr), 32'd0);
        push(9'h000, 10'd0); step();
        push(9'h001, 10'd1); step();

        // Halt at address 3
        reset = 1'b1; step(); reset = 1'b0;
        start = 1'b1; start_addr = 10'd0; step(); start = 1'b0;
        push(9'h000, 10'd0); step();
        push(9'h001, 10'd1); step();
        push(9'h002, 10'd2); step();
        push(9'h1FF, 10'd3); step();
        check("halt_shown_done", 32'(done), 32'h0);
        branch_req = 1'b1; branch_target = 10'd50; step(); branch_req = 1'b0;
        check("halt_done", 32'(done), 32'h1);
        check("halt_valid", 32'(instr_valid), 32'h0);
        check("halt_instruction", 32'(instruction), 32'h100);
        check("halt_rom_addr", 32'(rom_addr), 32'd4);
        check("halt_prog_counter", 32'(prog_counter), 32'd3);
        check("halt_count", 32'(cycle_count), exp_cnt(5));
        step(); step();
        check("halt_hold_done", 32'(done), 32'h1);
        check("halt_hold_rom_addr", 32'(rom_addr), 32'd4);
        check("halt_hold_count", 32'(cycle_count), exp_cnt(5));

        // Restart from HALT
        start = 1'b1; start_addr = 10'd0; step(); start = 1'b0;
        check("restart_done", 32'(done), 32'h0);
        check("restart_count", 32'(cycle_count), 32'h0);
        check("restart_rom_addr", 32'(rom_addr), 32'd0);
        check("restart_valid", 32'(instr_valid), 32'h0);
        push(9'h000, 10'd0); step();
        push(9'h001, 10'd1); step();
        push(9'h002, 10'd2); step();

        // Reset during a branch bubble
        branch_req = 1'b1; branch_target = 10'd30; step();
        check("bubble2_rom_addr", 32'(rom_addr), 32'd30);
        reset = 1'b1; step(); reset = 1'b0; branch_req = 1'b0;
        check("rst3_instruction", 32'(instruction), 32'h100);
        check("rst3_valid", 32'(instr_valid), 32'h0);
        check("rst3_prog_counter", 32'(prog_counter), 32'h0);
        check("rst3_rom_addr", 32'(rom_addr), 32'h0);
        check("rst3_done", 32'(done), 32'h0);
        step(); step();
        check("idle_no_fetch_valid", 32'(instr_valid), 32'h0);
        check("idle_no_fetch_addr", 32'(rom_addr), 32'h0);
        start = 1'b1; start_addr = 10'd30; step(); start = 1'b0;
        push(9'h01E, 10'd30); step();
        push(9'h01F, 10'd31); step();
        stall = 1'b1; step();

        @(negedge clk); #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
